// File: rtl/uart_tx_pkg.sv
// Shared encodings and constants for the UART TX FIFO reader and its bit timer.
// The pop is folded into IDLE, so the encoding has no dedicated POP state.
package uart_tx_pkg;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_START  = 3'd1;
   localparam logic [2:0] ST_DATA   = 3'd2;
   localparam logic [2:0] ST_PARITY = 3'd3;
   localparam logic [2:0] ST_STOP1  = 3'd4;
   localparam logic [2:0] ST_STOP2  = 3'd5;

   localparam int LCR_WLEN_LO = 0;
   localparam int LCR_WLEN_HI = 1;
   localparam int LCR_STOP    = 2;
   localparam int LCR_PEN     = 3;
   localparam int LCR_EPS     = 4;
   localparam int LCR_STICK   = 5;
   localparam int LCR_BREAK   = 6;

   localparam int TICKS_PER_BIT = 16;
   localparam int TICKS_HALF    = 8;

   // acc is the XOR of every data bit sent so far
   function automatic logic parity_bit(input logic [7:0] lcr, input logic acc);
      if (lcr[LCR_STICK]) return ~lcr[LCR_EPS];
      else if (lcr[LCR_EPS]) return acc;
      return ~acc;
   endfunction

endpackage

// File: rtl/uart_tx_bit_timer.sv
// Counts 16x baud enables within one bit time; bit_done fires on the 16th (or 8th with half) enable.
// Combinational bit_done in the enable clk; load holds the counter at zero.
module uart_tx_bit_timer
   import uart_tx_pkg::*;
(
   input  logic clk,
   input  logic wb_rst_i,
   input  logic enable,
   input  logic load,
   input  logic half,
   output logic bit_done
);

   logic [3:0] tick_q, tick_d;
   logic [3:0] term;

   assign term     = half ? 4'(TICKS_HALF - 1) : 4'(TICKS_PER_BIT - 1);
   assign bit_done = enable & ~load & (tick_q == term);

   always_comb begin
      tick_d = tick_q;
      if (load)
         tick_d = 4'd0;
      else if (enable)
         tick_d = bit_done ? 4'd0 : tick_q + 4'd1;
   end

   always_ff @(posedge clk) begin
      if (wb_rst_i) tick_q <= 4'd0;
      else          tick_q <= tick_d;
   end

endmodule

// File: rtl/uart_tx_fifo_reader.sv
// Pops bytes from the TX FIFO and serializes them with LCR framing; one pop per frame, paced by enable.
// UART_TX_BREAK_EN: when defined, lcr[6] forces the pad low while the FSM keeps running.
module uart_tx_fifo_reader
   import uart_tx_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int CNT_WIDTH  = 5
)(
   input  logic                  clk,
   input  logic                  wb_rst_i,
   input  logic                  enable,
   input  logic [7:0]            lcr,
   input  logic [CNT_WIDTH-1:0]  fifo_count,
   input  logic [DATA_WIDTH-1:0] fifo_data,
   output logic                  fifo_pop,
   output logic                  stx_pad_o,
   output logic                  tx_empty_o,
   output logic [2:0]            tstate
);

   logic [2:0] state_q, state_d;
   logic [7:0] shift_q, shift_d;
   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic       par_q, par_d;
   logic       pop_q, pop_d;
   logic       empty_q, empty_d;
   logic       bit_done, start_char, stx_fsm;
   logic [2:0] last_bit;
   logic       unused_bits;

   assign unused_bits = ^{fifo_data, lcr[7:6]};
   assign last_bit    = 3'd4 + {1'b0, lcr[LCR_WLEN_HI:LCR_WLEN_LO]};

   uart_tx_bit_timer u_bit_timer (
      .clk      (clk),
      .wb_rst_i (wb_rst_i),
      .enable   (enable),
      .load     (state_q == ST_IDLE),
      .half     ((state_q == ST_STOP2) && (lcr[LCR_WLEN_HI:LCR_WLEN_LO] == 2'b00)),
      .bit_done (bit_done)
   );

   always_comb begin
      state_d    = state_q;
      shift_d    = shift_q;
      bit_cnt_d  = bit_cnt_q;
      par_d      = par_q;
      pop_d      = 1'b0;
      start_char = 1'b0;
      case (state_q)
         ST_IDLE:   start_char = enable && (fifo_count != '0);
         ST_START:  if (bit_done) state_d = ST_DATA;
         ST_DATA: begin
            if (bit_done) begin
               par_d   = par_q ^ shift_q[0];
               shift_d = {1'b0, shift_q[7:1]};
               if (bit_cnt_q == last_bit) begin
                  bit_cnt_d = 3'd0;
                  state_d   = lcr[LCR_PEN] ? ST_PARITY : ST_STOP1;
               end else begin
                  bit_cnt_d = bit_cnt_q + 3'd1;
               end
            end
         end
         ST_PARITY: if (bit_done) state_d = ST_STOP1;
         // The final stop enable doubles as the IDLE slot so frames run back to back.
         ST_STOP1: begin
            if (bit_done) begin
               state_d    = lcr[LCR_STOP] ? ST_STOP2 : ST_IDLE;
               start_char = !lcr[LCR_STOP] && (fifo_count != '0);
            end
         end
         ST_STOP2: begin
            if (bit_done) begin
               state_d    = ST_IDLE;
               start_char = fifo_count != '0;
            end
         end
         default:   state_d = ST_IDLE;
      endcase
      if (start_char) begin
         pop_d     = 1'b1;
         shift_d   = fifo_data[7:0];
         par_d     = 1'b0;
         bit_cnt_d = 3'd0;
         state_d   = ST_START;
      end
      empty_d = (state_q == ST_IDLE) && (fifo_count == '0);
   end

   always_ff @(posedge clk) begin
      if (wb_rst_i) begin
         state_q   <= ST_IDLE;
         shift_q   <= 8'd0;
         bit_cnt_q <= 3'd0;
         par_q     <= 1'b0;
         pop_q     <= 1'b0;
         empty_q   <= 1'b1;
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         bit_cnt_q <= bit_cnt_d;
         par_q     <= par_d;
         pop_q     <= pop_d;
         empty_q   <= empty_d;
      end
   end

   always_comb begin
      case (state_q)
         ST_START:  stx_fsm = 1'b0;
         ST_DATA:   stx_fsm = shift_q[0];
         ST_PARITY: stx_fsm = parity_bit(lcr, par_q);
         default:   stx_fsm = 1'b1;
      endcase
   end

`ifdef UART_TX_BREAK_EN
   assign stx_pad_o = lcr[LCR_BREAK] ? 1'b0 : stx_fsm;
`else
   assign stx_pad_o = stx_fsm;
`endif

   assign fifo_pop   = pop_q;
   assign tx_empty_o = empty_q;
   assign tstate     = state_q;

endmodule

// File: tb/tb_uart_tx_fifo_reader.sv
// Bench for uart_tx_fifo_reader: emulates the TX FIFO and checks the pad against per-enable frame waveforms.
module tb_uart_tx_fifo_reader;

`ifdef UART_TX_BREAK_EN
   localparam bit BRK = 1'b1;
`else
   localparam bit BRK = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       wb_rst_i, enable;
   logic [7:0] lcr;
   logic [4:0] fifo_count;
   logic [7:0] fifo_data;
   logic       fifo_pop, stx, tx_empty;
   logic [2:0] tstate;

   int vectors     = 0;
   int miscompares = 0;

   logic [7:0] fifo_q[$];
   bit         exp_q[$];
   int         bnd_q[$];

   always #5 clk = ~clk;

   uart_tx_fifo_reader #(.DATA_WIDTH(8), .CNT_WIDTH(5)) dut (
      .clk        (clk),
      .wb_rst_i   (wb_rst_i),
      .enable     (enable),
      .lcr        (lcr),
      .fifo_count (fifo_count),
      .fifo_data  (fifo_data),
      .fifo_pop   (fifo_pop),
      .stx_pad_o  (stx),
      .tx_empty_o (tx_empty),
      .tstate     (tstate)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clear_model();
      fifo_q.delete();
      exp_q.delete();
      bnd_q.delete();
   endtask

   // Append one byte to the emulated FIFO and its frame (one entry per enable) to the expected stream.
   task automatic add_byte(input logic [7:0] l, input logic [7:0] d);
      int         nb;
      logic [7:0] m;
      logic       p;
      nb = 5 + int'(l[1:0]);
      m  = 8'hFF >> (8 - nb);
      fifo_q.push_back(d);
      bnd_q.push_back(exp_q.size());
      repeat (16) exp_q.push_back(1'b0);
      for (int i = 0; i < nb; i++) repeat (16) exp_q.push_back(d[i]);
      if (l[3]) begin
         if (l[5])      p = ~l[4];
         else if (l[4]) p = ^(d & m);
         else           p = ~(^(d & m));
         repeat (16) exp_q.push_back(p);
      end
      repeat (16) exp_q.push_back(1'b1);
      if (l[2]) repeat ((nb == 5) ? 8 : 16) exp_q.push_back(1'b1);
   endtask

   task automatic run(input int max_cyc, input bit rand_en);
      int   k, pops;
      logic exp_stx;
      k    = -1;
      pops = 0;
      fifo_count = 5'(fifo_q.size());
      fifo_data  = (fifo_q.size() > 0) ? fifo_q[0] : 8'($urandom);
      for (int cyc = 0; cyc < max_cyc; cyc++) begin
         enable = rand_en ? 1'($urandom_range(0, 1)) : 1'b1;
         @(posedge clk); #1;
         if (!enable) begin
            check("pop_without_enable", {31'd0, fifo_pop}, 0);
         end else begin
            if (k >= 0) k++;
            if (fifo_pop) begin
               if (k < 0) k = 0;
               if (pops < bnd_q.size()) check("pop_at_enable", k, bnd_q[pops]);
               else                     check("extra_pop", pops + 1, bnd_q.size());
               pops++;
               if (fifo_q.size() > 0) void'(fifo_q.pop_front());
               fifo_count = 5'(fifo_q.size());
               fifo_data  = (fifo_q.size() > 0) ? fifo_q[0] : 8'($urandom);
            end
            exp_stx = (k >= 0 && k < exp_q.size()) ? exp_q[k] : 1'b1;
            if (BRK && lcr[6]) exp_stx = 1'b0;
            check("stx", {31'd0, stx}, {31'd0, exp_stx});
            if (fifo_q.size() == 0 && (k < 0 || k > exp_q.size()))
               check("tx_empty_high", {31'd0, tx_empty}, 1);
            if (k >= 0 && k < exp_q.size())
               check("tx_empty_low", {31'd0, tx_empty}, 0);
         end
         if (bnd_q.size() > 0 && pops == bnd_q.size() && k > exp_q.size() + 2) break;
      end
      check("pop_total", pops, bnd_q.size());
      if (bnd_q.size() > 0) check("frame_finished", {31'd0, (k > exp_q.size())}, 1);
   endtask

   initial begin
      logic [7:0] l, d;
      bit         seen;
      int         n;

      wb_rst_i = 1'b1; enable = 1'b1; lcr = 8'h03; fifo_count = 5'd0; fifo_data = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      check("reset_stx", {31'd0, stx}, 1);
      check("reset_pop", {31'd0, fifo_pop}, 0);
      check("reset_tx_empty", {31'd0, tx_empty}, 1);
      check("reset_state", {29'd0, tstate}, 0);
      wb_rst_i = 1'b0;

      // idle line with an empty FIFO
      clear_model();
      run(100, 1'b0);

      // 8N1 0xA5
      clear_model(); lcr = 8'h03; add_byte(lcr, 8'hA5); run(400, 1'b0);

      // parity variants on 0x07
      clear_model(); lcr = 8'h1B; add_byte(lcr, 8'h07); run(400, 1'b0);
      clear_model(); lcr = 8'h0B; add_byte(lcr, 8'h07); run(400, 1'b0);
      clear_model(); lcr = 8'h3B; add_byte(lcr, 8'h07); run(400, 1'b0);

      // 5 bits with 1.5 stop bits; second byte checks the 120-enable frame length
      clear_model(); lcr = 8'h04; add_byte(lcr, 8'h1F); add_byte(lcr, 8'h1F); run(600, 1'b0);

      // three back-to-back frames
      clear_model(); lcr = 8'h03;
      add_byte(lcr, 8'h11); add_byte(lcr, 8'h22); add_byte(lcr, 8'h33);
      run(800, 1'b0);

      // randomized framing, data and enable pacing
      for (int t = 0; t < 8; t++) begin
         clear_model();
         l   = 8'($urandom) & 8'h7F;
         lcr = l;
         n   = $urandom_range(1, 3);
         for (int i = 0; i < n; i++) begin
            d = 8'($urandom);
            add_byte(l, d);
         end
         run(n * 900 + 100, t[0]);
      end

      // reset during data bit 3
      clear_model(); lcr = 8'h03; d = 8'h52;
      fifo_count = 5'd1; fifo_data = d; enable = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 50 && !seen; i++) begin
         @(posedge clk); #1;
         if (fifo_pop) seen = 1'b1;
      end
      check("reset_test_pop_seen", {31'd0, seen}, 1);
      fifo_count = 5'd0;
      repeat (16 + 3 * 16 + 5) @(posedge clk);
      #1;
      check("pre_reset_state", {29'd0, tstate}, 2);
      check("pre_reset_stx", {31'd0, stx}, {31'd0, d[3]});
      wb_rst_i = 1'b1;
      @(posedge clk); #1;
      check("mid_reset_stx", {31'd0, stx}, 1);
      check("mid_reset_state", {29'd0, tstate}, 0);
      check("mid_reset_pop", {31'd0, fifo_pop}, 0);
      wb_rst_i = 1'b0;
      run(20, 1'b0);

`ifdef UART_TX_BREAK_EN
      clear_model(); lcr = 8'h43; add_byte(lcr, 8'hA5); run(400, 1'b0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
